aes_inv_control: RTL and testbench

//  Iterative AES-128 decryption controller: inverse cipher of the aes_control encryptor (FIPS-197 sec 5.3).

---
 rtl/aes_inv_control_if.sv | 11 +
 rtl/aes_inv_control.sv | 199 +++++++++++++++++++
 tb/tb_aes_inv_control.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_control_if.sv
// Ciphertext-in / plaintext-out bundle for the AES-128 inverse cipher controller.
// Vectors are MSB-first: byte 0 occupies bits [127:120].
interface aes_inv_control_if;
   logic         ready;
   logic [127:0] data_in;
   logic         complete;
   logic [127:0] data_out;

   modport master (output ready, output data_in, input complete, input data_out);
   modport slave  (input ready, input data_in, output complete, output data_out);
endinterface

// File: rtl/aes_inv_control.sv
// Iterative AES-128 decryptor: expands KEY once after reset, then runs one inverse
// round per clock, so each accepted block produces plaintext 10 clocks later.
module aes_inv_control #(
   parameter logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c
) (
   input  logic              clk,
   input  logic              n_rst,
   aes_inv_control_if.slave  bus
);

   typedef enum logic [1:0] {KEYGEN, IDLE, ROUND} state_t;

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   // Table entry b starts at bit 8*(255-b)+7, which is {~b, 3'b111}.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b111} -: 8];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX[{~b, 3'b111} -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] key_step(input logic [127:0] p, input logic [7:0] rc);
      logic [31:0] rot, t, n0, n1, n2, n3;
      rot = {p[23:0], p[31:24]};
      t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
      n0  = p[127:96] ^ t;
      n1  = p[95:64]  ^ n0;
      n2  = p[63:32]  ^ n1;
      n3  = p[31:0]   ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // InvShiftRows then InvSubBytes; output byte (r,c) comes from input byte (r,c-r).
   function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
      logic [127:0] o;
      int k, src;
      o = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            k   = r + 4 * c;
            src = r + 4 * ((c - r + 4) % 4);
            o[127 - 8 * k -: 8] = inv_sbox(s[127 - 8 * src -: 8]);
         end
      end
      return o;
   endfunction

   // Coefficients 0e/0b/0d/09 assembled from x2, x4, x8 xtime chains.
   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a [4];
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31 - 8 * i -: 8];
         x2[i] = xtime(a[i]);
         x4[i] = xtime(x2[i]);
         x8[i] = xtime(x4[i]);
         m9[i] = x8[i] ^ a[i];
         mb[i] = x8[i] ^ x2[i] ^ a[i];
         md[i] = x8[i] ^ x4[i] ^ a[i];
         me[i] = x8[i] ^ x4[i] ^ x2[i];
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++) o[127 - 32 * c -: 32] = inv_mix_col(s[127 - 32 * c -: 32]);
      return o;
   endfunction

   state_t       state_q, state_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [127:0] st_q, st_d;
   logic [127:0] data_out_q, data_out_d;
   logic         complete_q, complete_d;
   logic [127:0] rk_q [11];
   logic [127:0] rk_d [11];

   logic [3:0]   kg_idx;
   logic [127:0] kg_prev, kg_next, rnd_out;

   // During KEYGEN rnd_q counts finished expansion steps; rk[0] is written alongside rk[1].
   assign kg_idx  = rnd_q + 4'd1;
   assign kg_prev = (rnd_q == 4'd0) ? KEY : rk_q[rnd_q];
   assign kg_next = key_step(kg_prev, rcon(kg_idx));
   assign rnd_out = inv_sr_sb(st_q) ^ rk_q[rnd_q];

   always_comb begin
      state_d    = state_q;
      rnd_d      = rnd_q;
      st_d       = st_q;
      data_out_d = data_out_q;
      complete_d = 1'b0;
      for (int i = 0; i < 11; i++) rk_d[i] = rk_q[i];
      case (state_q)
         KEYGEN: begin
            if (rnd_q == 4'd0) rk_d[0] = KEY;
            rk_d[kg_idx] = kg_next;
            if (rnd_q == 4'd9) begin
               state_d = IDLE;
               rnd_d   = 4'd0;
            end else begin
               rnd_d = kg_idx;
            end
         end
         IDLE: begin
            if (bus.ready) begin
               st_d    = bus.data_in ^ rk_q[10];
               rnd_d   = 4'd9;
               state_d = ROUND;
            end
         end
         ROUND: begin
            if (rnd_q == 4'd0) begin
               data_out_d = rnd_out;
               complete_d = 1'b1;
               state_d    = IDLE;
            end else begin
               st_d  = inv_mix(rnd_out);
               rnd_d = rnd_q - 4'd1;
            end
         end
         default: state_d = KEYGEN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q    <= KEYGEN;
         rnd_q      <= 4'd0;
         st_q       <= '0;
         data_out_q <= '0;
         complete_q <= 1'b0;
         for (int i = 0; i < 11; i++) rk_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         rnd_q      <= rnd_d;
         st_q       <= st_d;
         data_out_q <= data_out_d;
         complete_q <= complete_d;
         for (int i = 0; i < 11; i++) rk_q[i] <= rk_d[i];
      end
   end

   assign bus.complete = complete_q;
   assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_aes_inv_control.sv
// Scoreboard bench: a forward AES-128 model (S-box derived from GF(2^8) inverses)
// produces ciphertexts; the expected plaintext and completion cycle are queued per DUT.
module tb_aes_inv_control;

   localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

   typedef struct {
      logic [127:0] data;
      int           cyc;
   } exp_t;

   logic clk = 1'b0;
   logic n_rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   armed = 1'b0;

   exp_t         q0[$];
   exp_t         q1[$];
   logic [127:0] hold [2];
   int           idle_from [2];
   logic [7:0]   sb [256];

   aes_inv_control_if ifa ();
   aes_inv_control_if ifb ();

   aes_inv_control dut_a (.clk(clk), .n_rst(n_rst), .bus(ifa));
   aes_inv_control #(.KEY(KEY_B)) dut_b (.clk(clk), .n_rst(n_rst), .bus(ifb));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      repeat (8) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
         bb = bb >> 1;
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, r1, r2, r3, r4;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         r1 = {inv[6:0], inv[7]};
         r2 = {r1[6:0], r1[7]};
         r3 = {r2[6:0], r2[7]};
         r4 = {r3[6:0], r3[7]};
         sb[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] encrypt(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [127:0] o;
      rc = 8'h01;
      for (int i = 0; i < 44; i++) begin
         if (i < 4) w[i] = key[127 - 32 * i -: 32];
         else begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
               tmp = {tmp[23:0], tmp[31:24]};
               tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
               rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ tmp;
         end
      end
      for (int k = 0; k < 16; k++) s[k] = pt[127 - 8 * k -: 8] ^ w[k / 4][31 - 8 * (k % 4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int k = 0; k < 16; k++) s[k] = sb[s[k]];
         for (int rw = 0; rw < 4; rw++)
            for (int c = 0; c < 4; c++) t[rw + 4 * c] = s[rw + 4 * ((c + rw) % 4)];
         for (int c = 0; c < 4; c++) begin
            if (r < 10) begin
               s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
               s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
            end else begin
               for (int i = 0; i < 4; i++) s[4*c+i] = t[4*c+i];
            end
         end
         for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4 * r + k / 4][31 - 8 * (k % 4) -: 8];
      end
      for (int k = 0; k < 16; k++) o[127 - 8 * k -: 8] = s[k];
      return o;
   endfunction

   task automatic mon(input int d, input logic c, input logic [127:0] dout);
      exp_t e;
      int   n;
      n = (d == 0) ? q0.size() : q1.size();
      if (n > 0) e = (d == 0) ? q0[0] : q1[0];
      if (c === 1'b1) begin
         checks++;
         if (n == 0) begin
            errors++;
            $display("FAIL unexpected_complete dut%0d cyc=%0d data_out=%h", d, cyc, dout);
         end else begin
            if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            if (e.cyc != cyc) begin
               errors++;
               $display("FAIL latency dut%0d complete at cyc %0d, expected cyc %0d", d, cyc, e.cyc);
            end
            checks++;
            if (dout !== e.data) begin
               errors++;
               $display("FAIL plaintext dut%0d got %h expected %h", d, dout, e.data);
            end
            hold[d] = e.data;
         end
      end else begin
         checks++;
         if (c !== 1'b0) begin
            errors++;
            $display("FAIL complete_level dut%0d got %b expected 0", d, c);
         end else if (dout !== hold[d]) begin
            errors++;
            $display("FAIL data_out_hold dut%0d got %h expected %h", d, dout, hold[d]);
         end
         if (n > 0 && e.cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_complete dut%0d expected at cyc %0d, now %0d", d, e.cyc, cyc);
            if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
         end
      end
   endtask

   always @(negedge clk) begin
      if (armed) begin
         mon(0, ifa.complete, ifa.data_out);
         mon(1, ifb.complete, ifb.data_out);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called just after an edge; ready is sampled on the next edge (cyc+1).
   task automatic send(input int d, input logic [127:0] ct, input logic [127:0] pt);
      exp_t e;
      if (cyc + 1 >= idle_from[d]) begin
         e.data = pt;
         e.cyc  = cyc + 11;
         if (d == 0) q0.push_back(e); else q1.push_back(e);
         idle_from[d] = cyc + 12;
      end
      if (d == 0) begin ifa.ready = 1'b1; ifa.data_in = ct; end
      else        begin ifb.ready = 1'b1; ifb.data_in = ct; end
      tick(1);
      ifa.ready = 1'b0;
      ifb.ready = 1'b0;
      ifa.data_in = {$urandom, $urandom, $urandom, $urandom};
      ifb.data_in = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic apply_reset(input int n);
      n_rst = 1'b0;
      tick(1);
      q0.delete();
      q1.delete();
      hold[0] = '0;
      hold[1] = '0;
      armed = 1'b1;
      checks++;
      if (ifa.data_out !== '0 || ifa.complete !== 1'b0 || ifb.data_out !== '0 || ifb.complete !== 1'b0) begin
         errors++;
         $display("FAIL reset_values a=%b/%h b=%b/%h expected 0/0", ifa.complete, ifa.data_out,
                  ifb.complete, ifb.data_out);
      end
      tick(n - 1);
      n_rst = 1'b1;
      idle_from[0] = cyc + 11;
      idle_from[1] = cyc + 11;
   endtask

   task automatic wait_idle(input int d);
      int guard = 0;
      while (cyc + 1 < idle_from[d] && guard < 60) begin
         tick(1);
         guard++;
      end
   endtask

   logic [127:0] pt, ct, keyd;
   int           d;

   initial begin
      build_sbox();
      n_rst = 1'b0;
      ifa.ready = 1'b0; ifa.data_in = '0;
      ifb.ready = 1'b0; ifb.data_in = '0;
      apply_reset(3);

      // ready on every KEYGEN cycle is ignored; the first IDLE edge accepts
      while (cyc + 1 < idle_from[0]) send(0, 128'h3925841d02dc09fbdc118597196a0b32, 128'h0);
      send(0, 128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734);
      send(1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff);
      wait_idle(0);
      wait_idle(1);

      // back-to-back: second block issued in the complete cycle of the first
      pt = {$urandom, $urandom, $urandom, $urandom};
      send(0, encrypt(KEY_A, pt), pt);
      wait_idle(0);
      pt = {$urandom, $urandom, $urandom, $urandom};
      send(0, encrypt(KEY_A, pt), pt);
      wait_idle(0);
      tick(4);

      // stray ready pulses mid-block
      pt = {$urandom, $urandom, $urandom, $urandom};
      send(0, encrypt(KEY_A, pt), pt);
      tick(1);
      send(0, {$urandom, $urandom, $urandom, $urandom}, 128'h0);
      tick(3);
      send(0, {$urandom, $urandom, $urandom, $urandom}, 128'h0);
      wait_idle(0);
      tick(2);

      // reset mid-block aborts it, then the known vector decrypts again
      pt = {$urandom, $urandom, $urandom, $urandom};
      send(0, encrypt(KEY_A, pt), pt);
      send(1, encrypt(KEY_B, pt), pt);
      tick(2);
      apply_reset(2);
      wait_idle(0);
      send(0, 128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734);
      wait_idle(0);

      // random round trips with random gaps; some land while busy
      for (int i = 0; i < 30; i++) begin
         d    = int'($urandom_range(0, 1));
         keyd = (d == 0) ? KEY_A : KEY_B;
         pt   = {$urandom, $urandom, $urandom, $urandom};
         ct   = encrypt(keyd, pt);
         tick(int'($urandom_range(0, 12)));
         send(d, ct, pt);
      end

      wait_idle(0);
      wait_idle(1);
      tick(3);
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL drain pending a=%0d b=%0d expected 0/0", q0.size(), q1.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
